// File: rtl/onehot_request_sequencer.sv
// onehot_request_sequencer
// Captures rising edges on N request lines into a sticky pending register and
// serialises them into one-hot words with a 4-bit index under valid/ready.
// Optional feature: define ROUND_ROBIN_SEL_EN to rotate the selection start
// point after each loaded word; otherwise the lowest pending index wins.

module onehot_request_sequencer #(
    parameter int N    = 16,
    parameter int IDXW = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req_i,
    output logic [N-1:0]    onehot_o,
    output logic [IDXW-1:0] idx_o,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [N-1:0]    pend_o,
    output logic            ovf_o,
    input  logic            clr_ovf_i
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    localparam logic [N-1:0] ONE_BIT = {{(N-1){1'b0}}, 1'b1};

    state_t          state_q, state_d;
    logic [N-1:0]    req_q;
    logic [N-1:0]    pend_q, pend_d;
    logic [N-1:0]    onehot_q, onehot_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            ovf_q, ovf_d;
    logic [N-1:0]    rise;
    logic [N-1:0]    load;
    logic [IDXW-1:0] sel_idx;
    logic            sel_found;
    logic            take;
    logic            drop;
`ifdef ROUND_ROBIN_SEL_EN
    logic [IDXW-1:0] last_idx_q, last_idx_d;
    logic [IDXW-1:0] probe;
`endif

    // Pick the next index among events already pending before this edge
`ifdef ROUND_ROBIN_SEL_EN
    always_comb begin
        sel_idx   = '0;
        sel_found = 1'b0;
        probe     = '0;
        for (int k = 1; k <= N; k++) begin
            probe = last_idx_q + IDXW'(k);
            if (!sel_found && pend_q[probe]) begin
                sel_found = 1'b1;
                sel_idx   = probe;
            end
        end
    end
`else
    always_comb begin
        sel_idx   = '0;
        sel_found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                sel_found = 1'b1;
                sel_idx   = IDXW'(i);
            end
        end
    end
`endif

    // Output FSM: load a word when the slot is free or being consumed
    always_comb begin
        state_d  = state_q;
        onehot_d = onehot_q;
        idx_d    = idx_q;
        load     = '0;
        take     = (state_q == ST_EMPTY) || out_ready_i;
        if (take) begin
            if (sel_found) begin
                load     = ONE_BIT << sel_idx;
                onehot_d = ONE_BIT << sel_idx;
                idx_d    = sel_idx;
                state_d  = ST_FULL;
            end else begin
                onehot_d = '0;
                idx_d    = '0;
                state_d  = ST_EMPTY;
            end
        end
    end

    // Edge detection, pending bookkeeping and sticky overflow (set beats clear)
    always_comb begin
        rise   = req_i & ~req_q;
        pend_d = (pend_q & ~load) | rise;
        drop   = |(rise & pend_q & ~load);
        ovf_d  = ovf_q;
        if (clr_ovf_i) begin
            ovf_d = 1'b0;
        end
        if (drop) begin
            ovf_d = 1'b1;
        end
    end

`ifdef ROUND_ROBIN_SEL_EN
    // Remember the most recently loaded index as the rotation anchor
    always_comb begin
        last_idx_d = last_idx_q;
        if (take && sel_found) begin
            last_idx_d = sel_idx;
        end
    end
`endif

    // State registers; reset discards the word in flight and all pending events
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            req_q      <= '0;
            pend_q     <= '0;
            onehot_q   <= '0;
            idx_q      <= '0;
            ovf_q      <= 1'b0;
`ifdef ROUND_ROBIN_SEL_EN
            last_idx_q <= IDXW'(N - 1);
`endif
        end else begin
            state_q    <= state_d;
            req_q      <= req_i;
            pend_q     <= pend_d;
            onehot_q   <= onehot_d;
            idx_q      <= idx_d;
            ovf_q      <= ovf_d;
`ifdef ROUND_ROBIN_SEL_EN
            last_idx_q <= last_idx_d;
`endif
        end
    end

    assign onehot_o    = onehot_q;
    assign idx_o       = idx_q;
    assign out_valid_o = (state_q == ST_FULL);
    assign pend_o      = pend_q;
    assign ovf_o       = ovf_q;

endmodule
